// File: rtl/viterbi_pkg.sv
// Shared types and helpers for the Viterbi traceback engine.
package viterbi_pkg;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    FIND   = 2'd1,
    TRACE  = 2'd2,
    EMIT   = 2'd3
  } state_t;

  function automatic int unsigned state_width(input int unsigned n);
    return (n < 2) ? 32'd1 : 32'($clog2(n));
  endfunction

  // Decoded bit is the MSB of the state index (upper half of the trellis).
  function automatic logic decode_bit(input logic [31:0] s, input int unsigned sw);
    return s[5'(sw - 1)];
  endfunction

endpackage

// File: rtl/survivor_ram.sv
// Survivor pointer buffer: one row per trellis column, one write and one async read port.
module survivor_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 24,
  localparam int unsigned AW = (DEPTH < 2) ? 1 : $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/viterbi_traceback_engine.sv
// Viterbi traceback: buffers survivor columns, finds the best final state serially,
// walks the survivors back one column per cycle and streams bits oldest first.
module viterbi_traceback_engine
  import viterbi_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned NSTATES = 8,
  parameter int unsigned MW      = 4,
  parameter int unsigned SW      = state_width(NSTATES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NSTATES*MW-1:0] in_metrics,
  input  logic [NSTATES*SW-1:0] in_survivors,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_bit,
  output logic                  out_last,
  output logic [SW-1:0]         min_state,
  output logic                  busy
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned DW = $clog2(DEPTH);
  localparam int unsigned RW = NSTATES * SW;

  state_t                  state_q, state_d;
  logic [LW-1:0]           len_q, len_d;
  logic [NSTATES*MW-1:0]   metrics_q, metrics_d;
  logic [SW-1:0]           idx_q, idx_d;
  logic [SW-1:0]           best_q, best_d;
  logic [MW-1:0]           best_metric_q, best_metric_d;
  logic [SW-1:0]           cur_q, cur_d;
  logic [DW-1:0]           ptr_q, ptr_d;
  logic [DEPTH-1:0]        bits_q, bits_d;
  logic                    first_q, first_d;
  logic                    in_ready_d, busy_d, out_valid_d, out_bit_d, out_last_d;
  logic [SW-1:0]           min_state_d;

  logic                    accept;
  logic [RW-1:0]           rdata;
  logic [MW-1:0]           metric_arr [NSTATES];
  logic [SW-1:0]           surv_arr   [NSTATES];
  logic [MW-1:0]           cand;
  logic [DW-1:0]           widx;
  logic                    wbit;
  logic                    done;

  assign accept = in_valid & in_ready;

  survivor_ram #(.DEPTH(DEPTH), .WIDTH(RW)) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (DW'(len_q)),
    .wdata (in_survivors),
    .raddr (ptr_q),
    .rdata (rdata)
  );

  // Unpack the latched metrics and the survivor row being walked.
  always_comb begin
    for (int s = 0; s < NSTATES; s++) begin
      metric_arr[s] = metrics_q[s*MW +: MW];
      surv_arr[s]   = rdata[s*SW +: SW];
    end
  end

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    metrics_d     = metrics_q;
    idx_d         = idx_q;
    best_d        = best_q;
    best_metric_d = best_metric_q;
    cur_d         = cur_q;
    ptr_d         = ptr_q;
    bits_d        = bits_q;
    first_d       = 1'b0;
    out_valid_d   = out_valid;
    out_bit_d     = out_bit;
    out_last_d    = out_last;
    min_state_d   = min_state;
    cand          = metric_arr[idx_q];
    widx          = '0;
    wbit          = 1'b0;
    done          = 1'b0;

    case (state_q)
      ACCEPT: begin
        if (accept) begin
          metrics_d = in_metrics;
          len_d     = len_q + LW'(1);
          if (in_last || (len_q == LW'(DEPTH - 1))) begin
            state_d = FIND;
            idx_d   = '0;
          end
        end
      end
      FIND: begin
        // Strict less-than keeps the lowest index on ties.
        if ((idx_q == '0) || (cand < best_metric_q)) begin
          best_d        = idx_q;
          best_metric_d = cand;
        end
        idx_d = idx_q + SW'(1);
        if (idx_q == SW'(NSTATES - 1)) begin
          state_d = TRACE;
          first_d = 1'b1;
        end
      end
      TRACE: begin
        if (first_q) begin
          min_state_d = best_q;
          cur_d       = best_q;
          widx        = DW'(len_q - LW'(1));
          wbit        = decode_bit(32'(best_q), SW);
          done        = (len_q == LW'(1));
        end else begin
          cur_d = surv_arr[cur_q];
          widx  = ptr_q - DW'(1);
          wbit  = decode_bit(32'(surv_arr[cur_q]), SW);
          done  = (ptr_q == DW'(1));
        end
        ptr_d        = widx;
        bits_d[widx] = wbit;
        if (done) begin
          state_d     = EMIT;
          ptr_d       = '0;
          out_valid_d = 1'b1;
          out_bit_d   = wbit;
          out_last_d  = (len_q == LW'(1));
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (out_last) begin
            state_d     = ACCEPT;
            len_d       = '0;
            out_valid_d = 1'b0;
            out_bit_d   = 1'b0;
            out_last_d  = 1'b0;
          end else begin
            ptr_d      = ptr_q + DW'(1);
            out_bit_d  = bits_q[ptr_d];
            out_last_d = (ptr_d == DW'(len_q - LW'(1)));
          end
        end
      end
      default: state_d = ACCEPT;
    endcase

    in_ready_d = (state_d == ACCEPT);
    busy_d     = (state_d != ACCEPT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ACCEPT;
      len_q         <= '0;
      metrics_q     <= '0;
      idx_q         <= '0;
      best_q        <= '0;
      best_metric_q <= '0;
      cur_q         <= '0;
      ptr_q         <= '0;
      bits_q        <= '0;
      first_q       <= 1'b0;
      in_ready      <= 1'b1;
      busy          <= 1'b0;
      out_valid     <= 1'b0;
      out_bit       <= 1'b0;
      out_last      <= 1'b0;
      min_state     <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      metrics_q     <= metrics_d;
      idx_q         <= idx_d;
      best_q        <= best_d;
      best_metric_q <= best_metric_d;
      cur_q         <= cur_d;
      ptr_q         <= ptr_d;
      bits_q        <= bits_d;
      first_q       <= first_d;
      in_ready      <= in_ready_d;
      busy          <= busy_d;
      out_valid     <= out_valid_d;
      out_bit       <= out_bit_d;
      out_last      <= out_last_d;
      min_state     <= min_state_d;
    end
  end

endmodule

// File: doc/viterbi_traceback_engine.md
Name: viterbi_traceback_engine

Overview:
Sequential traceback/decision unit for the parametrised Viterbi decoder. It accepts one trellis column per handshake: path metrics plus survivor (predecessor) pointers for every state. At frame end it finds the minimum-metric final state with a serial compare, backtracks one column per cycle, and streams decoded bits in chronological order. It sits between the ACS (add-compare-select) array and the output bit sink, and supports variable frame length up to DEPTH.

Parameters:
DEPTH, 8, maximum trellis columns per frame (>=2)
NSTATES, 8, trellis states; power of two, >=2
MW, 4, path-metric width (unsigned)
SW, $clog2(NSTATES), state index width (derived; do not override)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  column valid
in_ready  out  1  engine can accept a column
in_metrics  in  NSTATES*MW  path metric of state s at bits [s*MW +: MW]
in_survivors  in  NSTATES*SW  predecessor of state s at bits [s*SW +: SW]
in_last  in  1  column is final column of frame
out_valid  out  1  decoded bit valid
out_ready  in  1  sink accepts bit
out_bit  out  1  decoded bit
out_last  out  1  final decoded bit of frame
min_state  out  SW  winning final state (stable from TRACE until next frame)
busy  out  1  high in any state except ACCEPT

Behaviour:
- Reset values: state=ACCEPT; column count L=0; in_ready=1; out_valid=0; out_bit=0; out_last=0; min_state=0; busy=0. Reset mid-operation aborts the frame immediately; buffered data is discarded and no partial output is emitted.
- FSM: ACCEPT -> FIND -> TRACE -> EMIT -> ACCEPT.
- ACCEPT: in_ready=1. Handshake is in_valid&in_ready. The survivors of column k are written to survivor RAM row k, and L increments. Only the metrics of the most recent column are kept (metric register). The frame ends on a handshake carrying in_last=1, or on the DEPTH-th column regardless of in_last. Either case moves the FSM to FIND.
- FIND: exactly NSTATES cycles, examining index i=0..NSTATES-1 one per cycle. Index 0 loads best. Each later index replaces best only on a strict less-than, so on a tie the lowest state index wins. Unsigned compare; no saturation required.
- TRACE: exactly L cycles. Cycle 0 sets path[L-1]=best and min_state=best. Each following cycle t sets path[L-1-t]=survivor RAM[L-t][path[L-t]]. Survivors of column 0 are never read.
- Decoded bit for column k = MSB of path[k], i.e. 1 when path[k] >= NSTATES/2.
- EMIT: out_valid=1 from the first EMIT cycle. Bits are presented for k=0..L-1. out_bit/out_last are held stable while out_valid&!out_ready. out_last=1 only for k=L-1. After the last bit is accepted, the FSM returns to ACCEPT on the next cycle with L=0.
- Latency from last input handshake to first out_valid: NSTATES+L+1 cycles. Throughput is one bit per cycle when out_ready=1.
- in_ready=0 in FIND/TRACE/EMIT. in_valid is ignored there; no input is lost because the upstream block must hold it.
- L=1 frame: TRACE is 1 cycle; a single bit is emitted with out_last=1.

Decomposition:
- Shared package viterbi_pkg: FSM state enum (ACCEPT, FIND, TRACE, EMIT), localparam SW helper, and a decode_bit function (MSB of state).
- One natural sub-module: survivor_ram (DEPTH rows x NSTATES*SW bits, 1 write/1 read port, async read). Holds the buffer so it can later be mapped to block RAM.

Test Plan:
1. All metrics 0, all survivors 0, DEPTH=8 columns with no in_last -> FIND picks 0; 8 bits of 0 emitted; out_last on the 8th; latency 8+8+1 cycles.
2. L=3 (in_last on col 2); col2 metrics {9,9,9,9,9,2,9,9}; col2 surv[5]=6; col1 surv[6]=1 -> min_state=5, path {1,6,5}, bits 0,1,1.
3. Tie: final metrics all 7 except states 3 and 6 = 1 -> min_state=3.
4. EMIT with out_ready toggling 1,0,0,1 -> out_bit/out_last held during stalls; each bit emitted exactly once; in_ready stays 0 until EMIT completes.
5. Single column with in_last=1 and metric minimum at state 4 -> one bit =1, out_last=1.
6. Assert rst during TRACE -> next cycle out_valid=0, in_ready=1, busy=0; new frame decodes correctly with no stale bits.
